// File: rtl/fetch_pc_unit.sv
// Instruction-fetch and next-PC stage: handshaked fetch, one-instruction hold
// for execute, branch/jump resolution, self-loop halt and fetch-timeout trap.
//
// state | meaning
// IDLE  | one cycle after reset before the first fetch
// FETCH | imem_req high, waiting for imem_ready (bounded by TIMEOUT)
// EXEC  | instruction held; next PC resolved when stall is low
// HALT  | absorbing; left only through reset
module fetch_pc_unit #(
    parameter int              PC_W     = 12,
    parameter logic [PC_W-1:0] RESET_PC = '0,
    parameter int              TIMEOUT  = 15
) (
    input  logic            clk,
    input  logic            reset,
    output logic [PC_W-1:0] imem_addr,
    output logic            imem_req,
    input  logic [15:0]     imem_rdata,
    input  logic            imem_ready,
    output logic [15:0]     instr,
    output logic [3:0]      opcode,
    output logic            instr_valid,
    output logic [PC_W-1:0] pc,
    input  logic            jump,
    input  logic            beq,
    input  logic            bne,
    input  logic            blt,
    input  logic            bgt,
    input  logic            alu_zero,
    input  logic            alu_lt,
    input  logic            alu_gt,
    input  logic            stall,
    output logic            illegal_op,
    output logic            halted,
    output logic            fetch_err
);

    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_EXEC, S_HALT} state_t;

    localparam logic [PC_W-1:0] PC_ONE    = PC_W'(1);
    localparam logic [7:0]      WAIT_LAST = 8'(TIMEOUT - 1);

    state_t          state, state_nx;
    logic [7:0]      wait_cnt, wait_cnt_nx;
    logic [15:0]     instr_nx;
    logic [PC_W-1:0] pc_nx;
    logic            fetch_err_nx;
    logic            first_exec, first_exec_nx;

    logic [PC_W-1:0] target, offset_ext, pc_inc, pc_branch;
    logic            taken, opcode_bad;

    assign opcode    = instr[15:12];
    assign imem_addr = pc;

    // Jump target zero-extends/truncates instr[11:0]; offset sign-extends instr[3:0].
    always_comb begin
        target     = '0;
        offset_ext = '0;
        for (int i = 0; i < PC_W; i++) begin
            if (i < 12) target[i] = instr[i];
            offset_ext[i] = (i < 4) ? instr[i] : instr[3];
        end
    end

    assign pc_inc     = pc + PC_ONE;
    assign pc_branch  = pc_inc + offset_ext;
    assign taken      = (beq & alu_zero) | (bne & ~alu_zero) | (blt & alu_lt) | (bgt & alu_gt);
    assign opcode_bad = (opcode == 4'h5) || (opcode == 4'h6) ||
                        (opcode == 4'hD) || (opcode == 4'hE);

    always_comb begin
        state_nx      = state;
        pc_nx         = pc;
        instr_nx      = instr;
        wait_cnt_nx   = wait_cnt;
        fetch_err_nx  = fetch_err;
        first_exec_nx = 1'b0;
        imem_req      = 1'b0;
        instr_valid   = 1'b0;
        illegal_op    = 1'b0;
        halted        = 1'b0;
        case (state)
            S_IDLE: state_nx = S_FETCH;
            S_FETCH: begin
                imem_req = 1'b1;
                if (imem_ready) begin
                    instr_nx      = imem_rdata;
                    wait_cnt_nx   = '0;
                    first_exec_nx = 1'b1;
                    state_nx      = S_EXEC;
                end else if (wait_cnt == WAIT_LAST) begin
                    fetch_err_nx = 1'b1;
                    state_nx     = S_HALT;
                end else begin
                    wait_cnt_nx = wait_cnt + 8'd1;
                end
            end
            S_EXEC: begin
                instr_valid = 1'b1;
                illegal_op  = first_exec & opcode_bad;
                if (!stall) begin
                    state_nx = S_FETCH;
                    if (jump) begin
                        if (target == pc) state_nx = S_HALT;
                        else              pc_nx    = target;
                    end else if (taken) begin
                        // offset -1 branches back onto itself
                        if (instr[3:0] == 4'hF) state_nx = S_HALT;
                        else                    pc_nx    = pc_branch;
                    end else begin
                        pc_nx = pc_inc;
                    end
                end
            end
            S_HALT:  halted   = 1'b1;
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            pc         <= RESET_PC;
            instr      <= '0;
            wait_cnt   <= '0;
            fetch_err  <= 1'b0;
            first_exec <= 1'b0;
        end else begin
            state      <= state_nx;
            pc         <= pc_nx;
            instr      <= instr_nx;
            wait_cnt   <= wait_cnt_nx;
            fetch_err  <= fetch_err_nx;
            first_exec <= first_exec_nx;
        end
    end

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Directed bench for fetch_pc_unit: sequential fetch, branches, jumps, wrap,
// wait states, stall, illegal opcode, halt/timeout traps and reset dominance.
module tb_fetch_pc_unit;

    localparam int PC_W = 12;

    localparam logic [4:0] C_NONE = 5'b00000;
    localparam logic [4:0] C_JMP  = 5'b10000;
    localparam logic [4:0] C_BEQ  = 5'b01000;
    localparam logic [4:0] C_BLT  = 5'b00010;
    localparam logic [2:0] F_NONE = 3'b000;
    localparam logic [2:0] F_Z    = 3'b100;
    localparam logic [2:0] F_LT   = 3'b010;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic [PC_W-1:0] imem_addr;
    logic            imem_req;
    logic [15:0]     imem_rdata = '0;
    logic            imem_ready = 1'b0;
    logic [15:0]     instr;
    logic [3:0]      opcode;
    logic            instr_valid;
    logic [PC_W-1:0] pc;
    logic            jump = 0, beq = 0, bne = 0, blt = 0, bgt = 0;
    logic            alu_zero = 0, alu_lt = 0, alu_gt = 0;
    logic            stall = 1'b0;
    logic            illegal_op, halted, fetch_err;

    int n_checks = 0;
    int n_fail   = 0;

    fetch_pc_unit #(.PC_W(PC_W), .RESET_PC(12'h000), .TIMEOUT(15)) dut (
        .clk(clk), .reset(reset),
        .imem_addr(imem_addr), .imem_req(imem_req),
        .imem_rdata(imem_rdata), .imem_ready(imem_ready),
        .instr(instr), .opcode(opcode), .instr_valid(instr_valid), .pc(pc),
        .jump(jump), .beq(beq), .bne(bne), .blt(blt), .bgt(bgt),
        .alu_zero(alu_zero), .alu_lt(alu_lt), .alu_gt(alu_gt),
        .stall(stall), .illegal_op(illegal_op), .halted(halted), .fetch_err(fetch_err)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Waits (bounded) for FETCH, returns the word, then drives decoder/ALU inputs for one EXEC cycle.
    task automatic run_instr(input logic [15:0] word, input logic [4:0] ctl, input logic [2:0] flg);
        int n = 0;
        while (imem_req !== 1'b1 && n < 40) begin step(); n++; end
        n_checks++;
        if (imem_req !== 1'b1) begin
            n_fail++;
            $display("FAIL fetch_wait: imem_req=%b required 1", imem_req);
        end
        imem_ready = 1'b1; imem_rdata = word;
        step();
        imem_ready = 1'b0; imem_rdata = '0;
        {jump, beq, bne, blt, bgt} = ctl;
        {alu_zero, alu_lt, alu_gt} = flg;
        step();
        {jump, beq, bne, blt, bgt} = C_NONE;
        {alu_zero, alu_lt, alu_gt} = F_NONE;
    endtask

    task automatic test_reset();
        reset = 1'b1; imem_ready = 1'b1; imem_rdata = 16'hFFFF; jump = 1'b1;
        step(); step();
        n_checks++; if (pc !== 12'h000) begin n_fail++; $display("FAIL reset_pc: got %h required 000", pc); end
        n_checks++; if (instr !== 16'h0000) begin n_fail++; $display("FAIL reset_instr: got %h required 0000", instr); end
        n_checks++; if ({imem_req, instr_valid, illegal_op, halted, fetch_err} !== 5'b0)
            begin n_fail++; $display("FAIL reset_outputs: got %b required 00000", {imem_req, instr_valid, illegal_op, halted, fetch_err}); end
        imem_ready = 1'b0; imem_rdata = '0; jump = 1'b0;
        reset = 1'b0;
        step();
        n_checks++; if (imem_req !== 1'b1 || imem_addr !== 12'h000)
            begin n_fail++; $display("FAIL reset_first_fetch: req=%b addr=%h required 1/000", imem_req, imem_addr); end
    endtask

    task automatic test_sequential();
        imem_ready = 1'b1; imem_rdata = 16'h1123;
        step();
        imem_ready = 1'b0; imem_rdata = '0;
        n_checks++; if (instr !== 16'h1123) begin n_fail++; $display("FAIL seq_instr: got %h required 1123", instr); end
        n_checks++; if (opcode !== 4'b0001) begin n_fail++; $display("FAIL seq_opcode: got %b required 0001", opcode); end
        n_checks++; if (instr_valid !== 1'b1 || imem_req !== 1'b0)
            begin n_fail++; $display("FAIL seq_exec: valid=%b req=%b required 1/0", instr_valid, imem_req); end
        step();
        n_checks++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL seq_valid_once: got %b required 0", instr_valid); end
        n_checks++; if (pc !== 12'h001 || imem_addr !== 12'h001)
            begin n_fail++; $display("FAIL seq_next_pc: pc=%h addr=%h required 001", pc, imem_addr); end
    endtask

    task automatic test_branch();
        run_instr(16'hF005, C_JMP, F_NONE);
        run_instr(16'h800E, C_BEQ, F_Z);
        n_checks++; if (pc !== 12'h004) begin n_fail++; $display("FAIL beq_taken: got %h required 004", pc); end
        run_instr(16'hF005, C_JMP, F_NONE);
        run_instr(16'h800E, C_BEQ, F_NONE);
        n_checks++; if (pc !== 12'h006) begin n_fail++; $display("FAIL beq_not_taken: got %h required 006", pc); end
        run_instr(16'hF005, C_JMP, F_NONE);
        run_instr(16'h8003, C_BLT, F_LT);
        n_checks++; if (pc !== 12'h009) begin n_fail++; $display("FAIL blt_taken: got %h required 009", pc); end
    endtask

    task automatic test_jump_wrap();
        run_instr(16'hF010, C_JMP, F_NONE);
        run_instr(16'hF7A0, C_JMP, F_NONE);
        n_checks++; if (pc !== 12'h7A0) begin n_fail++; $display("FAIL jump_target: got %h required 7a0", pc); end
        run_instr(16'hFFFF, C_JMP, F_NONE);
        run_instr(16'h1000, C_NONE, F_NONE);
        n_checks++; if (pc !== 12'h000) begin n_fail++; $display("FAIL wrap_up: got %h required 000", pc); end
        run_instr(16'h8008, C_BEQ, F_Z);
        n_checks++; if (pc !== 12'hFF9) begin n_fail++; $display("FAIL wrap_down: got %h required ff9", pc); end
    endtask

    task automatic test_wait_states();
        int req_cnt = 0;
        for (int i = 0; i < 3; i++) begin
            if (imem_req === 1'b1) req_cnt++;
            step();
        end
        if (imem_req === 1'b1) req_cnt++;
        imem_ready = 1'b1; imem_rdata = 16'h1000;
        step();
        imem_ready = 1'b0; imem_rdata = '0;
        n_checks++; if (req_cnt !== 4) begin n_fail++; $display("FAIL wait_req_cycles: got %0d required 4", req_cnt); end
        n_checks++; if (instr_valid !== 1'b1) begin n_fail++; $display("FAIL wait_exec: got %b required 1", instr_valid); end
        step();
        n_checks++; if (instr_valid !== 1'b0 || pc !== 12'hFFA)
            begin n_fail++; $display("FAIL wait_single_exec: valid=%b pc=%h required 0/ffa", instr_valid, pc); end
    endtask

    task automatic test_stall();
        int v_cnt = 0;
        imem_ready = 1'b1; imem_rdata = 16'h1000;
        step();
        imem_ready = 1'b0; imem_rdata = '0;
        stall = 1'b1;
        if (instr_valid === 1'b1) v_cnt++;
        step();
        if (instr_valid === 1'b1) v_cnt++;
        n_checks++; if (pc !== 12'hFFA) begin n_fail++; $display("FAIL stall_pc_hold: got %h required ffa", pc); end
        step();
        if (instr_valid === 1'b1) v_cnt++;
        stall = 1'b0;
        step();
        n_checks++; if (v_cnt !== 3) begin n_fail++; $display("FAIL stall_valid_cycles: got %0d required 3", v_cnt); end
        n_checks++; if (pc !== 12'hFFB || instr_valid !== 1'b0)
            begin n_fail++; $display("FAIL stall_release: pc=%h valid=%b required ffb/0", pc, instr_valid); end
    endtask

    task automatic test_illegal();
        imem_ready = 1'b1; imem_rdata = 16'h5000;
        step();
        imem_ready = 1'b0; imem_rdata = '0;
        n_checks++; if (illegal_op !== 1'b1) begin n_fail++; $display("FAIL illegal_pulse: got %b required 1", illegal_op); end
        stall = 1'b1;
        step();
        n_checks++; if (illegal_op !== 1'b0 || instr_valid !== 1'b1)
            begin n_fail++; $display("FAIL illegal_once: illegal=%b valid=%b required 0/1", illegal_op, instr_valid); end
        stall = 1'b0;
        step();
        n_checks++; if (pc !== 12'hFFC) begin n_fail++; $display("FAIL illegal_seq_pc: got %h required ffc", pc); end
    endtask

    task automatic test_halt_jump();
        run_instr(16'hF020, C_JMP, F_NONE);
        run_instr(16'hF020, C_JMP, F_NONE);
        n_checks++; if (halted !== 1'b1 || pc !== 12'h020)
            begin n_fail++; $display("FAIL halt_self_jump: halted=%b pc=%h required 1/020", halted, pc); end
        imem_ready = 1'b1; jump = 1'b1;
        step(); step(); step();
        imem_ready = 1'b0; jump = 1'b0;
        n_checks++; if (imem_req !== 1'b0 || instr_valid !== 1'b0 || halted !== 1'b1)
            begin n_fail++; $display("FAIL halt_absorb: req=%b valid=%b halted=%b required 0/0/1", imem_req, instr_valid, halted); end
        reset = 1'b1;
        step();
        n_checks++; if (halted !== 1'b0 || pc !== 12'h000)
            begin n_fail++; $display("FAIL halt_reset: halted=%b pc=%h required 0/000", halted, pc); end
        reset = 1'b0;
    endtask

    task automatic test_halt_branch();
        run_instr(16'h800F, C_BEQ, F_Z);
        n_checks++; if (halted !== 1'b1 || pc !== 12'h000 || fetch_err !== 1'b0)
            begin n_fail++; $display("FAIL halt_branch_m1: halted=%b pc=%h err=%b required 1/000/0", halted, pc, fetch_err); end
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    task automatic test_timeout();
        step();
        imem_ready = 1'b0;
        repeat (14) step();
        n_checks++; if (imem_req !== 1'b1 || fetch_err !== 1'b0)
            begin n_fail++; $display("FAIL timeout_early: req=%b err=%b required 1/0", imem_req, fetch_err); end
        step();
        n_checks++; if (fetch_err !== 1'b1 || halted !== 1'b1 || imem_req !== 1'b0)
            begin n_fail++; $display("FAIL timeout_trap: err=%b halted=%b req=%b required 1/1/0", fetch_err, halted, imem_req); end
        reset = 1'b1;
        step();
        n_checks++; if (fetch_err !== 1'b0 || halted !== 1'b0)
            begin n_fail++; $display("FAIL timeout_reset: err=%b halted=%b required 0/0", fetch_err, halted); end
        reset = 1'b0;
        step();
    endtask

    task automatic test_mid_reset();
        run_instr(16'hF123, C_JMP, F_NONE);
        n_checks++; if (pc !== 12'h123 || imem_req !== 1'b1)
            begin n_fail++; $display("FAIL midreset_setup: pc=%h req=%b required 123/1", pc, imem_req); end
        imem_ready = 1'b1; imem_rdata = 16'hABCD; reset = 1'b1;
        step();
        n_checks++; if (instr !== 16'h0000 || pc !== 12'h000)
            begin n_fail++; $display("FAIL midreset_regs: instr=%h pc=%h required 0000/000", instr, pc); end
        n_checks++; if (imem_req !== 1'b0 || instr_valid !== 1'b0)
            begin n_fail++; $display("FAIL midreset_idle: req=%b valid=%b required 0/0", imem_req, instr_valid); end
        imem_ready = 1'b0; imem_rdata = '0; reset = 1'b0;
        step();
        n_checks++; if (imem_req !== 1'b1 || instr !== 16'h0000)
            begin n_fail++; $display("FAIL midreset_fetch: req=%b instr=%h required 1/0000", imem_req, instr); end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_branch();
        test_jump_wrap();
        test_wait_states();
        test_stall();
        test_illegal();
        test_halt_jump();
        test_halt_branch();
        test_timeout();
        test_mid_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_pc_unit.md
Name: fetch_pc_unit

Overview:
- Instruction-fetch and next-PC stage of the 16-bit processor.
- Fetches from a handshaked instruction memory and holds the instruction for one execute cycle.
- Drives the opcode into the control decoder.
- Consumes the decoder's jump/beq/bne/blt/bgt outputs together with ALU flags to compute and register the next PC.

Parameters:
- PC_W, 12: PC / instruction-memory word-address width.
- RESET_PC, 0: PC value loaded on reset.
- TIMEOUT, 15: maximum FETCH wait cycles for imem_ready before a fetch error (1..255).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- imem_addr  out  PC_W  word address of the instruction being fetched (equals pc).
- imem_req  out  1  fetch request, high only in FETCH.
- imem_rdata  in  16  instruction word, valid when imem_ready=1.
- imem_ready  in  1  memory handshake; sampled only in FETCH.
- instr  out  16  registered instruction.
- opcode  out  4  instr[15:12], to the control decoder.
- instr_valid  out  1  high for exactly the EXEC cycle.
- pc  out  PC_W  current PC register.
- jump, beq, bne, blt, bgt  in  1 each  control decoder outputs.
- alu_zero, alu_lt, alu_gt  in  1 each  ALU compare flags for the executing instruction.
- stall  in  1  holds EXEC (datapath busy).
- illegal_op  out  1  one-cycle pulse when EXEC holds opcode 0101, 0110, 1101 or 1110.
- halted  out  1  high in HALT.
- fetch_err  out  1  sticky; set on fetch timeout.

Behaviour:
- Reset (synchronous, dominates all inputs, also mid-fetch or mid-EXEC):
  - pc=RESET_PC, instr=0, state=IDLE, wait counter=0, fetch_err=0.
  - instr_valid, imem_req, illegal_op, halted all 0.
- Instruction fields:
  - opcode=instr[15:12].
  - Branch offset = sign-extended instr[3:0], range -8..+7.
  - Jump target = instr[11:0], truncated or zero-extended to PC_W.
- States: IDLE, FETCH, EXEC, HALT.
  - IDLE: -> FETCH next cycle. All outputs low.
  - FETCH:
    - imem_req=1, imem_addr=pc.
    - If imem_ready=1: instr<=imem_rdata, counter cleared, -> EXEC. Fetch latency is 1 cycle minimum.
    - Else counter increments. When counter reaches TIMEOUT with imem_ready still 0: fetch_err<=1, -> HALT.
  - EXEC:
    - instr_valid=1.
    - If stall=1: remain in EXEC, pc and instr held, instr_valid stays 1.
    - Else compute next PC, load it, -> FETCH. Exception: halt detection (below) -> HALT.
    - illegal_op pulses on the first EXEC cycle only; an illegal opcode otherwise executes as pc+1.
  - HALT: absorbing until reset. imem_req=0, instr_valid=0, halted=1.
- Next-PC computation (EXEC, stall=0):
  - taken = (beq & alu_zero) | (bne & ~alu_zero) | (blt & alu_lt) | (bgt & alu_gt). Multiple flags are ORed.
  - Priority: jump > taken > sequential.
  - jump: pc <= target.
  - taken: pc <= pc + 1 + sext(offset).
  - otherwise: pc <= pc + 1.
  - All arithmetic is modulo 2^PC_W (wrap-around both directions, no error).
- Halt detection:
  - jump=1 with target == pc (jump-to-self) -> HALT; pc is unchanged.
  - A taken branch with offset -1 is also self-looping -> HALT.
- Control inputs and ALU flags are ignored outside EXEC.
- imem_rdata is ignored when imem_ready=0.

Test Plan:
- Reset then sequential fetch: memory returns 0x1123 at addr 0 with ready on the first FETCH cycle.
  - Required: instr=0x1123, opcode=0001, instr_valid high 1 cycle, then pc=1, imem_addr=1.
- Branch taken/not taken from pc=5, offset instr[3:0]=0xE (-2):
  - beq=1, alu_zero=1 -> pc=4.
  - Same with alu_zero=0 -> pc=6.
  - blt=1, alu_lt=1, offset +3 -> pc=9.
- Jump and wrap:
  - From pc=0x010, jump=1, instr[11:0]=0x7A0 -> pc=0x7A0.
  - From pc=0xFFF, no branch -> pc=0x000.
  - From pc=0x000, taken branch with offset -8 -> pc=0xFF9.
- Stall and wait states:
  - imem_ready delayed 3 cycles -> imem_req high 4 cycles, single EXEC.
  - stall high 2 cycles in EXEC -> instr_valid high 3 cycles, pc changes once.
- Halt and error paths:
  - Jump to self at pc=0x020 -> halted=1, imem_req=0 thereafter.
  - imem_ready held 0 for TIMEOUT cycles -> fetch_err=1, halted=1.
  - Reset clears both.
- Illegal opcode and mid-operation reset:
  - Opcode 0101 -> illegal_op one pulse, pc+1.
  - reset asserted during FETCH with imem_ready=1 -> instr stays 0, pc=RESET_PC, IDLE then FETCH.
